pen_move_sequencer: RTL and testbench
=====================================

# pen_move_sequencer

Sequences one plotter draw command across the two actuator controllers: it sets the pen (servo) position first, then runs the XY motor move, and signals completion once both have finished. It sits between the command decoder and the servo and XY-motor controllers. It owns the servo and motor trigger lines. It tracks the current pen position so redundant servo moves are skipped.

## Interface
- POS_WIDTH, 16: width of the signed dx/dy move deltas.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- clk_en  in  1  module enable; state and registers advance only when high.
- trigger  in  1  start command; sampled only when rdy && clk_en.
- pen_pos  in  ServoPos_t  requested pen position.
- dx, dy  in  POS_WIDTH (signed)  requested XY move deltas.
- servo_rdy  in  1  servo controller ready to be triggered.
- motor_rdy  in  1  XY motor controller ready to be triggered.
- servo_trigger  out  1  trigger to the servo controller.
- servo_pos  out  ServoPos_t  latched pen position, presented to the servo controller.
- motor_trigger  out  1  trigger to the motor controller.
- motor_dx, motor_dy  out  POS_WIDTH  latched deltas, presented to the motor controller.
- done  out  1  one-cycle completion pulse.
- rdy  out  1  idle and able to accept a trigger.

## Operation
- On accept, the block latches pen_pos, dx and dy into command registers. These registers drive servo_pos, motor_dx and motor_dy and stay stable until the next accept.
- cur_pen register tracks the current pen position. Reset value is SERVO_POS_DOWN, matching the servo controller's reset position.
- FSM states:
  - IDLE: rdy=1.
    - trigger with pen_pos != cur_pen → SERVO_TRIG.
    - otherwise, trigger with dx|dy != 0 → MOTOR_TRIG.
    - otherwise, trigger → DONE.
  - SERVO_TRIG: servo_trigger=1, held until servo_rdy==0 (controller has accepted), then → SERVO_WAIT.
  - SERVO_WAIT: wait for servo_rdy==1, then update cur_pen with the latched pen position.
    - dx|dy != 0 → MOTOR_TRIG.
    - otherwise → DONE.
  - MOTOR_TRIG: motor_trigger=1, held until motor_rdy==0, then → MOTOR_WAIT.
  - MOTOR_WAIT: wait for motor_rdy==1, then → DONE.
  - DONE: done=1, rdy=0, then → IDLE.
  - Illegal or unknown state → IDLE.
- In every state other than IDLE, rdy=0. A trigger arriving while busy is ignored (not queued).
- The servo trigger is issued only when servo_rdy==1 on entry. If servo_rdy==0 on entry, SERVO_TRIG keeps servo_trigger=0 until servo_rdy rises, then asserts it. The motor trigger follows the same rule with motor_rdy.
- Completion is judged from the rdy fall-then-rise sequence only. Sub-block done levels are not used, so that a done line held high while a sub-block is idle cannot be mistaken for completion.

## Timing
- Reset values: rdy=1 (state IDLE), done=0, servo_trigger=0, motor_trigger=0, servo_pos=SERVO_POS_DOWN, motor_dx=0, motor_dy=0, cur_pen=SERVO_POS_DOWN.
- All transitions take effect on a clk edge where clk_en=1. With clk_en=0, every output holds its current value.
- Null command (same pen position, zero deltas): trigger → done 1 cycle later → rdy 2 cycles later.
- Minimum overhead per actuator phase: 2 enabled cycles (TRIG and WAIT) plus the sub-block's own latency.
- Trigger and the command inputs are sampled in the same enabled cycle that rdy=1.
- Reset during any state returns to IDLE on the next edge. Both triggers drop in that same cycle. The actuator controllers are reset by the same reset, so cur_pen resets with them.
- Deltas are passed through unmodified: no saturation and no sign handling. Zero is tested as the full bitwise OR of dx and dy.

## Structure
- Servo_PKG (existing) supplies ServoPos_t, SERVO_POS_UP and SERVO_POS_DOWN.
- The FSM state enum stays local to the FSM sub-module.
- Sub-module pen_move_sequencer_fsm: pure FSM; drives triggers, done and rdy, plus the latch/update strobes.
- Top level pen_move_sequencer: holds the command registers and cur_pen, instantiates the FSM.

## Test plan
- After reset: rdy=1, done=0, cur_pen=DOWN. Command pen=DOWN, dx=0, dy=0 → no servo or motor trigger; done pulses 1 cycle after trigger; rdy returns 2 cycles after trigger.
- Pen=UP, dx=10, dy=-5 with stub controllers (servo 20 cycles, motor 50 cycles) → servo_trigger first. motor_trigger only after servo_rdy returns high. motor_dx=10, motor_dy=-5 (0xFFFB). Single done pulse.
- Second command pen=UP, dx=3, dy=0 → servo skipped; motor triggered directly.
- servo_rdy held low for 7 cycles on entry to SERVO_TRIG → servo_trigger stays 0 for those 7 cycles, then asserts. Triggers applied while busy have no effect.
- clk_en toggled every other cycle during a full command → identical state sequence; completion takes twice as many clk cycles.
- Reset asserted during MOTOR_WAIT → next cycle rdy=1, motor_trigger=0, done=0, cur_pen=DOWN.

Source files
------------

// File: rtl/Servo_PKG.sv
// Servo controller shared types: the two pen positions the servo can hold.
package Servo_PKG;
  typedef enum logic {
    SERVO_POS_DOWN = 1'b0,
    SERVO_POS_UP   = 1'b1
  } ServoPos_t;
endpackage

// File: rtl/pen_move_sequencer_pkg.sv
// Shared constants for the pen move sequencer slice.
package pen_move_sequencer_pkg;
  localparam int POS_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/pen_move_sequencer_fsm.sv
// Pen/XY move FSM: servo phase then motor phase; triggers are registered and
// issued only while the target reports ready, then held until it drops ready.
module pen_move_sequencer_fsm (
  input  logic clk,
  input  logic reset,
  input  logic i_clk_en,
  input  logic i_trigger,
  input  logic i_pen_change,
  input  logic i_move_req,
  input  logic i_move_lat,
  input  logic i_servo_rdy,
  input  logic i_motor_rdy,
  output logic o_servo_trigger,
  output logic o_motor_trigger,
  output logic o_done,
  output logic o_rdy,
  output logic o_cmd_latch,
  output logic o_pen_update
);
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SERVO_TRIG = 3'd1;
  localparam logic [2:0] ST_SERVO_WAIT = 3'd2;
  localparam logic [2:0] ST_MOTOR_TRIG = 3'd3;
  localparam logic [2:0] ST_MOTOR_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_servo_trig;
  logic       r_motor_trig;
  logic       w_servo_trig_nx;
  logic       w_motor_trig_nx;

  always_comb begin
    w_next          = r_state;
    w_servo_trig_nx = r_servo_trig;
    w_motor_trig_nx = r_motor_trig;
    case (r_state)
      ST_IDLE: begin
        if (i_trigger) begin
          if (i_pen_change) begin
            w_next          = ST_SERVO_TRIG;
            w_servo_trig_nx = i_servo_rdy;
          end else if (i_move_req) begin
            w_next          = ST_MOTOR_TRIG;
            w_motor_trig_nx = i_motor_rdy;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      // Trigger goes up only once the servo is ready; the ready drop is its ack.
      ST_SERVO_TRIG: begin
        if (!r_servo_trig) begin
          w_servo_trig_nx = i_servo_rdy;
        end else if (!i_servo_rdy) begin
          w_servo_trig_nx = 1'b0;
          w_next          = ST_SERVO_WAIT;
        end
      end
      ST_SERVO_WAIT: begin
        if (i_servo_rdy) begin
          if (i_move_lat) begin
            w_next          = ST_MOTOR_TRIG;
            w_motor_trig_nx = i_motor_rdy;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_MOTOR_TRIG: begin
        if (!r_motor_trig) begin
          w_motor_trig_nx = i_motor_rdy;
        end else if (!i_motor_rdy) begin
          w_motor_trig_nx = 1'b0;
          w_next          = ST_MOTOR_WAIT;
        end
      end
      ST_MOTOR_WAIT: begin
        if (i_motor_rdy) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: begin
        w_next          = ST_IDLE;
        w_servo_trig_nx = 1'b0;
        w_motor_trig_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_servo_trig <= 1'b0;
      r_motor_trig <= 1'b0;
    end else if (i_clk_en) begin
      r_state      <= w_next;
      r_servo_trig <= w_servo_trig_nx;
      r_motor_trig <= w_motor_trig_nx;
    end
  end

  assign o_rdy           = (r_state == ST_IDLE);
  assign o_done          = (r_state == ST_DONE);
  assign o_servo_trigger = r_servo_trig;
  assign o_motor_trigger = r_motor_trig;
  assign o_cmd_latch     = i_clk_en & o_rdy & i_trigger;
  assign o_pen_update    = i_clk_en & (r_state == ST_SERVO_WAIT) & i_servo_rdy;
endmodule

// File: rtl/pen_move_sequencer.sv
// Sequences one draw command: pen servo move (skipped if already there), then XY move.
// Holds the command registers and the tracked pen position; control lives in the FSM.
module pen_move_sequencer
  import Servo_PKG::*;
  import pen_move_sequencer_pkg::*;
#(
  parameter int POS_WIDTH = POS_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        trigger,
  input  ServoPos_t                   pen_pos,
  input  logic signed [POS_WIDTH-1:0] dx,
  input  logic signed [POS_WIDTH-1:0] dy,
  input  logic                        servo_rdy,
  input  logic                        motor_rdy,
  output logic                        servo_trigger,
  output ServoPos_t                   servo_pos,
  output logic                        motor_trigger,
  output logic        [POS_WIDTH-1:0] motor_dx,
  output logic        [POS_WIDTH-1:0] motor_dy,
  output logic                        done,
  output logic                        rdy
);
  ServoPos_t            r_servo_pos;
  ServoPos_t            r_cur_pen;
  logic [POS_WIDTH-1:0] r_dx;
  logic [POS_WIDTH-1:0] r_dy;
  logic                 w_cmd_latch;
  logic                 w_pen_update;
  logic                 w_pen_change;
  logic                 w_move_req;
  logic                 w_move_lat;

  assign w_pen_change = (pen_pos != r_cur_pen);
  assign w_move_req   = |{dx, dy};
  assign w_move_lat   = |{r_dx, r_dy};

  // cur_pen resets with the servo controller, so DOWN is a true reflection after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_servo_pos <= SERVO_POS_DOWN;
      r_cur_pen   <= SERVO_POS_DOWN;
      r_dx        <= '0;
      r_dy        <= '0;
    end else begin
      if (w_cmd_latch) begin
        r_servo_pos <= pen_pos;
        r_dx        <= dx;
        r_dy        <= dy;
      end
      if (w_pen_update) r_cur_pen <= r_servo_pos;
    end
  end

  pen_move_sequencer_fsm u_fsm (
    .clk             (clk),
    .reset           (reset),
    .i_clk_en        (clk_en),
    .i_trigger       (trigger),
    .i_pen_change    (w_pen_change),
    .i_move_req      (w_move_req),
    .i_move_lat      (w_move_lat),
    .i_servo_rdy     (servo_rdy),
    .i_motor_rdy     (motor_rdy),
    .o_servo_trigger (servo_trigger),
    .o_motor_trigger (motor_trigger),
    .o_done          (done),
    .o_rdy           (rdy),
    .o_cmd_latch     (w_cmd_latch),
    .o_pen_update    (w_pen_update)
  );

  assign servo_pos = r_servo_pos;
  assign motor_dx  = r_dx;
  assign motor_dy  = r_dy;
endmodule

// File: tb/tb_pen_move_sequencer.sv
// Directed bench for pen_move_sequencer with servo/motor stub controllers.
module tb_pen_move_sequencer;
  import Servo_PKG::*;

  localparam int PW     = 16;
  localparam int SV_LAT = 20;
  localparam int MT_LAT = 50;
  localparam int MAXC   = 400;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_en;
  logic                 trigger;
  ServoPos_t            pen_pos;
  ServoPos_t            servo_pos;
  logic signed [PW-1:0] dx;
  logic signed [PW-1:0] dy;
  logic                 servo_rdy;
  logic                 motor_rdy;
  logic                 servo_trigger;
  logic                 motor_trigger;
  logic        [PW-1:0] motor_dx;
  logic        [PW-1:0] motor_dy;
  logic                 done;
  logic                 rdy;

  logic sv_stub_rdy;
  logic mt_stub_rdy;
  logic sv_block;
  int   sv_cnt;
  int   mt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pen_move_sequencer #(.POS_WIDTH(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .trigger       (trigger),
    .pen_pos       (pen_pos),
    .dx            (dx),
    .dy            (dy),
    .servo_rdy     (servo_rdy),
    .motor_rdy     (motor_rdy),
    .servo_trigger (servo_trigger),
    .servo_pos     (servo_pos),
    .motor_trigger (motor_trigger),
    .motor_dx      (motor_dx),
    .motor_dy      (motor_dy),
    .done          (done),
    .rdy           (rdy)
  );

  // Stub controllers: accept a trigger while ready, then stay busy for a fixed time.
  assign servo_rdy = sv_stub_rdy & ~sv_block;
  assign motor_rdy = mt_stub_rdy;

  always @(posedge clk) begin
    if (reset) begin
      sv_stub_rdy <= 1'b1;
      sv_cnt      <= 0;
    end else if (clk_en) begin
      if (sv_cnt != 0) begin
        sv_cnt <= sv_cnt - 1;
        if (sv_cnt == 1) sv_stub_rdy <= 1'b1;
      end else if (servo_trigger && servo_rdy) begin
        sv_stub_rdy <= 1'b0;
        sv_cnt      <= SV_LAT;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mt_stub_rdy <= 1'b1;
      mt_cnt      <= 0;
    end else if (clk_en) begin
      if (mt_cnt != 0) begin
        mt_cnt <= mt_cnt - 1;
        if (mt_cnt == 1) mt_stub_rdy <= 1'b1;
      end else if (motor_trigger && motor_rdy) begin
        mt_stub_rdy <= 1'b0;
        mt_cnt      <= MT_LAT;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command and watches it to completion; cycle c counts negedges after the accept edge.
  task automatic run_cmd(input ServoPos_t p, input logic signed [PW-1:0] x, input logic signed [PW-1:0] y,
                         input bit tog, input bit blk,
                         output int done_at, output int rdy_at, output int sv_first, output int mt_first,
                         output int n_done, output int sv_rises, output int mt_rises, output logic sv_rdy_at_mt);
    logic p_sv, p_mt, p_d;
    done_at = 0; rdy_at = 0; sv_first = 0; mt_first = 0;
    n_done = 0; sv_rises = 0; mt_rises = 0; sv_rdy_at_mt = 1'b0;
    p_sv = 1'b0; p_mt = 1'b0; p_d = 1'b0;
    @(negedge clk);
    pen_pos = p; dx = x; dy = y; trigger = 1'b1; clk_en = 1'b1;
    if (blk) sv_block = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      if (c == 1) trigger = 1'b0;
      if (tog) clk_en = (c % 2 == 0);
      if (blk) begin
        if (c <= 7) chk("blk_sv_trig_low", 32'(servo_trigger), 0);
        if (c == 3) begin trigger = 1'b1; pen_pos = SERVO_POS_UP; dx = 16'sd5; end
        if (c == 4) trigger = 1'b0;
        if (c == 7) sv_block = 1'b0;
        if (c == 8) chk("blk_sv_trig_high", 32'(servo_trigger), 1);
      end
      if (servo_trigger && !p_sv) begin
        sv_rises++;
        if (sv_first == 0) sv_first = c;
      end
      if (motor_trigger && !p_mt) begin
        mt_rises++;
        if (mt_first == 0) begin mt_first = c; sv_rdy_at_mt = servo_rdy; end
      end
      if (done && !p_d) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      p_sv = servo_trigger; p_mt = motor_trigger; p_d = done;
      if (done_at != 0 && rdy && !done) begin
        rdy_at = c;
        break;
      end
    end
    clk_en = 1'b1;
    trigger = 1'b0;
    if (rdy_at == 0) chk("cmd_timeout", 0, 1);
  endtask

  initial begin
    int d_at, r_at, s1, m1, nd, sr, mr;
    logic srm;
    reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; sv_block = 1'b0;
    pen_pos = SERVO_POS_DOWN; dx = '0; dy = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_sv_trig", 32'(servo_trigger), 0);
    chk("rst_mt_trig", 32'(motor_trigger), 0);
    chk("rst_servo_pos", 32'(servo_pos), 32'(SERVO_POS_DOWN));
    chk("rst_motor_dx", 32'(motor_dx), 0);
    chk("rst_motor_dy", 32'(motor_dy), 0);
    chk("rst_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_DOWN));

    // Null command: done on the first cycle, rdy on the second.
    run_cmd(SERVO_POS_DOWN, 16'sd0, 16'sd0, 1'b0, 1'b0, d_at, r_at, s1, m1, nd, sr, mr, srm);
    chk("null_done_at", 32'(d_at), 1);
    chk("null_rdy_at", 32'(r_at), 2);
    chk("null_done_cnt", 32'(nd), 1);
    chk("null_sv_rises", 32'(sr), 0);
    chk("null_mt_rises", 32'(mr), 0);

    // Full move: servo 20-cycle stub, motor 50-cycle stub; done after edge 74.
    run_cmd(SERVO_POS_UP, 16'sd10, -16'sd5, 1'b0, 1'b0, d_at, r_at, s1, m1, nd, sr, mr, srm);
    chk("full_sv_first", 32'(s1), 1);
    chk("full_mt_first", 32'(m1), 23);
    chk("full_sv_rdy_at_mt", 32'(srm), 1);
    chk("full_sv_rises", 32'(sr), 1);
    chk("full_mt_rises", 32'(mr), 1);
    chk("full_done_cnt", 32'(nd), 1);
    chk("full_done_at", 32'(d_at), 75);
    chk("full_motor_dx", 32'(motor_dx), 32'h000A);
    chk("full_motor_dy", 32'(motor_dy), 32'hFFFB);
    chk("full_servo_pos", 32'(servo_pos), 32'(SERVO_POS_UP));
    chk("full_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_UP));

    // Same pen position: servo skipped, motor only.
    run_cmd(SERVO_POS_UP, 16'sd3, 16'sd0, 1'b0, 1'b0, d_at, r_at, s1, m1, nd, sr, mr, srm);
    chk("skip_sv_rises", 32'(sr), 0);
    chk("skip_mt_rises", 32'(mr), 1);
    chk("skip_mt_first", 32'(m1), 1);
    chk("skip_done_at", 32'(d_at), 53);
    chk("skip_motor_dx", 32'(motor_dx), 32'h0003);
    chk("skip_motor_dy", 32'(motor_dy), 0);

    // Servo not ready for 7 cycles on entry; busy trigger with new values is ignored.
    run_cmd(SERVO_POS_DOWN, 16'sd0, 16'sd0, 1'b0, 1'b1, d_at, r_at, s1, m1, nd, sr, mr, srm);
    chk("blk_sv_rises", 32'(sr), 1);
    chk("blk_mt_rises", 32'(mr), 0);
    chk("blk_done_cnt", 32'(nd), 1);
    chk("blk_done_at", 32'(d_at), 30);
    chk("blk_servo_pos", 32'(servo_pos), 32'(SERVO_POS_DOWN));
    chk("blk_motor_dx", 32'(motor_dx), 0);
    chk("blk_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_DOWN));

    // Half-rate enable: every enabled edge lands on an even clk edge, so edges double.
    run_cmd(SERVO_POS_UP, 16'sd1, 16'sd1, 1'b1, 1'b0, d_at, r_at, s1, m1, nd, sr, mr, srm);
    chk("en_sv_first", 32'(s1), 1);
    chk("en_mt_first", 32'(m1), 45);
    chk("en_done_at", 32'(d_at), 149);
    chk("en_done_cnt", 32'(nd), 1);
    chk("en_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_UP));

    // Reset mid motor wait.
    @(negedge clk);
    pen_pos = SERVO_POS_UP; dx = 16'sd7; dy = 16'sd0; trigger = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) trigger = 1'b0;
    end
    chk("prerst_rdy", 32'(rdy), 0);
    chk("prerst_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_UP));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 32'(rdy), 1);
    chk("midrst_mt_trig", 32'(motor_trigger), 0);
    chk("midrst_sv_trig", 32'(servo_trigger), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_cur_pen", 32'(dut.r_cur_pen), 32'(SERVO_POS_DOWN));
    chk("midrst_motor_dx", 32'(motor_dx), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_rdy", 32'(rdy), 1);
    chk("postrst_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
